// File: rtl/rib_ram_slave_pkg.sv
// Shared RIB widths, hold-flag levels, FSM encoding and address-decode helpers
// for the RAM-backed RIB data-memory responder.
package rib_ram_slave_pkg;

  localparam int RIB_DW = 32;
  localparam int RIB_AW = 32;

  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Unsigned offset compare also rejects addresses below base, since they wrap high.
  function automatic logic addr_in_range(input logic [RIB_AW-1:0] addr,
                                         input logic [RIB_AW-1:0] base,
                                         input logic [RIB_AW-1:0] span);
    logic [RIB_AW-1:0] off;
    off = addr - base;
    return (off < span);
  endfunction

  function automatic logic [RIB_AW-1:0] word_offset(input logic [RIB_AW-1:0] addr,
                                                    input logic [RIB_AW-1:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/rib_sram_1r1w.sv
// Word-wide RAM with one synchronous write port and one registered read port;
// a same-edge read of the word being written returns the old contents.
module rib_sram_1r1w
  import rib_ram_slave_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [RIB_DW-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [RIB_DW-1:0] rdata
);

  logic [RIB_DW-1:0] mem_r [DEPTH];

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/rib_ram_slave.sv
// RIB data-memory responder: address decode, optional wait-state FSM driving
// the core hold flag, sticky range error, backed by rib_sram_1r1w.
module rib_ram_slave
  import rib_ram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr_rib_req_i,
  input  logic              mem_wr_en_i,
  input  logic [RIB_AW-1:0] mem_wr_addr_i,
  input  logic [RIB_DW-1:0] mem_wr_data_i,
  input  logic              mem_rd_rib_req_i,
  input  logic [RIB_AW-1:0] mem_rd_addr_i,
  output logic [RIB_DW-1:0] mem_rd_data_o,
  output logic              rib_hold_flag_o,
  output logic              err_o
);

  localparam int                AW   = $clog2(DEPTH);
  localparam logic [RIB_AW-1:0] SPAN = RIB_AW'(DEPTH) << 2;

  logic              wr_req_s, rd_req_s;
  logic              c_wr_s, c_rd_s;
  logic [RIB_AW-1:0] c_waddr_s, c_raddr_s;
  logic [RIB_DW-1:0] c_wdata_s;
  logic              wr_ok_s, rd_ok_s;
  logic [AW-1:0]     wr_idx_s, rd_idx_s;
  logic [RIB_DW-1:0] sram_rdata_s;
  logic              rd_oor_r;

  assign wr_req_s = mem_wr_rib_req_i & mem_wr_en_i;
  assign rd_req_s = mem_rd_rib_req_i;

  if (WAIT_CYCLES == 0) begin : g_nowait
    assign c_wr_s          = wr_req_s;
    assign c_rd_s          = rd_req_s;
    assign c_waddr_s       = mem_wr_addr_i;
    assign c_raddr_s       = mem_rd_addr_i;
    assign c_wdata_s       = mem_wr_data_i;
    assign rib_hold_flag_o = HOLD_DISABLE;
  end else begin : g_wait
    state_e            state_r, state_nxt_s;
    logic [3:0]        cnt_r, cnt_nxt_s;
    logic              commit_s, hold_s;
    logic              l_wr_r, l_rd_r;
    logic [RIB_AW-1:0] l_waddr_r, l_raddr_r;
    logic [RIB_DW-1:0] l_wdata_r;

    // State, counter and request capture; live inputs are only sampled in IDLE.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r   <= IDLE;
        cnt_r     <= 4'd0;
        l_wr_r    <= 1'b0;
        l_rd_r    <= 1'b0;
        l_waddr_r <= '0;
        l_raddr_r <= '0;
        l_wdata_r <= '0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        if (state_r == IDLE && (wr_req_s || rd_req_s)) begin
          l_wr_r    <= wr_req_s;
          l_rd_r    <= rd_req_s;
          l_waddr_r <= mem_wr_addr_i;
          l_raddr_r <= mem_rd_addr_i;
          l_wdata_r <= mem_wr_data_i;
        end else begin
          l_wr_r <= l_wr_r;
        end
      end
    end

    // Next state, countdown and hold; hold rises in the request cycle itself.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      commit_s    = 1'b0;
      hold_s      = HOLD_DISABLE;
      case (state_r)
        IDLE: begin
          if ((wr_req_s || rd_req_s) && !rst) begin
            state_nxt_s = BUSY;
            cnt_nxt_s   = 4'(WAIT_CYCLES);
            hold_s      = HOLD_ENABLE;
          end else begin
            hold_s = HOLD_DISABLE;
          end
        end
        BUSY: begin
          hold_s    = HOLD_ENABLE;
          cnt_nxt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = IDLE;
            commit_s    = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end

    assign c_wr_s          = commit_s & l_wr_r;
    assign c_rd_s          = commit_s & l_rd_r;
    assign c_waddr_s       = l_waddr_r;
    assign c_raddr_s       = l_raddr_r;
    assign c_wdata_s       = l_wdata_r;
    assign rib_hold_flag_o = hold_s;
  end

  assign wr_ok_s  = addr_in_range(c_waddr_s, BASE_ADDR, SPAN);
  assign rd_ok_s  = addr_in_range(c_raddr_s, BASE_ADDR, SPAN);
  assign wr_idx_s = AW'(word_offset(c_waddr_s, BASE_ADDR));
  assign rd_idx_s = AW'(word_offset(c_raddr_s, BASE_ADDR));

  rib_sram_1r1w #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .we    (c_wr_s & wr_ok_s & ~rst),
    .waddr (wr_idx_s),
    .wdata (c_wdata_s),
    .re    (c_rd_s & rd_ok_s & ~rst),
    .raddr (rd_idx_s),
    .rdata (sram_rdata_s)
  );

  // Out-of-range read masking flag and sticky error, both set on the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_oor_r <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (c_rd_s) begin
        rd_oor_r <= ~rd_ok_s;
      end else begin
        rd_oor_r <= rd_oor_r;
      end
      if ((c_wr_s && !wr_ok_s) || (c_rd_s && !rd_ok_s)) begin
        err_o <= 1'b1;
      end else begin
        err_o <= err_o;
      end
    end
  end

  assign mem_rd_data_o = rd_oor_r ? '0 : sram_rdata_s;

endmodule

// File: tb/tb_rib_ram_slave.sv
// Directed table-driven bench for rib_ram_slave: four instances (WAIT 0,3,5,2)
// share one stimulus stream; per-instance outputs are checked.
module tb_rib_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0, wr_en = 1'b0, rd_req = 1'b0;
  logic [31:0] wr_addr = 32'h0, wr_data = 32'h0, rd_addr = 32'h0;
  logic [31:0] rd_data [4];
  logic        hold [4];
  logic        err [4];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    rib_ram_slave #(
      .BASE_ADDR   (32'h1000_0000),
      .DEPTH       (4096),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 2)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .mem_wr_rib_req_i (wr_req),
      .mem_wr_en_i      (wr_en),
      .mem_wr_addr_i    (wr_addr),
      .mem_wr_data_i    (wr_data),
      .mem_rd_rib_req_i (rd_req),
      .mem_rd_addr_i    (rd_addr),
      .mem_rd_data_o    (rd_data[g]),
      .rib_hold_flag_o  (hold[g]),
      .err_o            (err[g])
    );
  end

  typedef struct {
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rd;
    logic [31:0] ra;
    logic [31:0] exp_d;
    logic        exp_err;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic clear_inputs();
    wr_req = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    #1;
    while ((hold[0] | hold[1] | hold[2] | hold[3]) && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    check1({name, "_idle"}, hold[0] | hold[1] | hold[2] | hold[3], 1'b0);
  endtask

  // One request cycle, then inputs dropped until every instance is idle.
  task automatic do_access(input string name, input logic wr, input logic [31:0] wa,
                           input logic [31:0] wd, input logic rd, input logic [31:0] ra);
    @(negedge clk);
    wr_req = wr; wr_en = wr; wr_addr = wa; wr_data = wd;
    rd_req = rd; rd_addr = ra;
    #1;
    check1({name, "_hold_w0"}, hold[0], 1'b0);
    check1({name, "_hold_w3"}, hold[1], 1'b1);
    check1({name, "_hold_w5"}, hold[2], 1'b1);
    check1({name, "_hold_w2"}, hold[3], 1'b1);
    @(negedge clk);
    clear_inputs();
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0,          32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 32'h0,          32'h0,         1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b0, 32'h0,          32'h0,         1'b1, 32'h1000_000B, 32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h1000_0013, 32'h1234_5678, 1'b0, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{1'b1, 32'h1000_0014, 32'h0000_00AA, 1'b0, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{1'b1, 32'h1000_0014, 32'h5555_5555, 1'b1, 32'h1000_0014, 32'h0000_00AA, 1'b0};
    vt[6]  = '{1'b0, 32'h0,          32'h0,         1'b1, 32'h1000_0014, 32'h5555_5555, 1'b0};
    vt[7]  = '{1'b1, 32'h1000_0020, 32'h1111_1111, 1'b0, 32'h0,          32'h5555_5555, 1'b0};
    vt[8]  = '{1'b1, 32'h1000_0000, 32'h0000_0F0F, 1'b0, 32'h0,          32'h5555_5555, 1'b0};
    vt[9]  = '{1'b1, 32'h1000_3FFC, 32'h0BAD_F00D, 1'b0, 32'h0,          32'h5555_5555, 1'b0};
    vt[10] = '{1'b1, 32'h0FFF_FFFC, 32'hBAD0_BAD0, 1'b1, 32'h1000_4000, 32'h0000_0000, 1'b1};
    vt[11] = '{1'b0, 32'h0,          32'h0,         1'b1, 32'h1000_3FFC, 32'h0BAD_F00D, 1'b1};
    vt[12] = '{1'b0, 32'h0,          32'h0,         1'b1, 32'h1000_0000, 32'h0000_0F0F, 1'b1};
    vt[13] = '{1'b0, 32'h0,          32'h0,         1'b1, 32'h1000_0010, 32'h1234_5678, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_rd_u%0d", i), rd_data[i], 32'h0);
      check1($sformatf("reset_hold_u%0d", i), hold[i], 1'b0);
      check1($sformatf("reset_err_u%0d", i), err[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table: every instance must produce the same functional result
    for (int v = 0; v < 14; v++) begin
      do_access($sformatf("vec%0d", v), vt[v].wr, vt[v].wa, vt[v].wd, vt[v].rd, vt[v].ra);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_rd_u%0d", v, i), rd_data[i], vt[v].exp_d);
        check1($sformatf("vec%0d_err_u%0d", v, i), err[i], vt[v].exp_err);
      end
    end

    // WAIT=3: hold for 4 cycles, live inputs ignored while busy
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h1000_0010;
    #1;
    check1("w3_hold_c0", hold[1], 1'b1);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      wr_req = 1'b1; wr_en = 1'b1; wr_addr = 32'h1000_0010; wr_data = 32'hFFFF_FFFF;
      rd_addr = 32'h1000_0008;
      #1;
      check1($sformatf("w3_hold_c%0d", c), hold[1], 1'b1);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    check1("w3_hold_c4", hold[1], 1'b0);
    check("w3_data_c4", rd_data[1], 32'h1234_5678);
    wait_idle("w3_settle");
    do_access("w3_reread", 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000_0010);
    check("w3_reread_u1", rd_data[1], 32'h1234_5678);
    check("w3_reread_u2", rd_data[2], 32'h1234_5678);

    // WAIT=5: reset at BUSY cycle 2 discards the pending write
    @(negedge clk);
    wr_req = 1'b1; wr_en = 1'b1; wr_addr = 32'h1000_0020; wr_data = 32'hCAFE_F00D;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("rstmid_hold_u2", hold[2], 1'b0);
    check("rstmid_rd_u2", rd_data[2], 32'h0);
    check1("rstmid_hold_u1", hold[1], 1'b0);
    for (int i = 0; i < 4; i++) begin
      check1($sformatf("rstmid_err_u%0d", i), err[i], 1'b0);
    end
    do_access("rstmid_read", 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000_0020);
    check("rstmid_old_u2", rd_data[2], 32'h1111_1111);
    check("rstmid_old_u1", rd_data[1], 32'h1111_1111);
    check("rstmid_old_u3", rd_data[3], 32'h1111_1111);
    check("rstmid_new_u0", rd_data[0], 32'hCAFE_F00D);

    // WAIT=2: three back-to-back reads with no gap cycle
    do_access("b2b_pre0", 1'b1, 32'h1000_0030, 32'hA1A1_A1A1, 1'b0, 32'h0);
    do_access("b2b_pre1", 1'b1, 32'h1000_0034, 32'hB2B2_B2B2, 1'b0, 32'h0);
    do_access("b2b_pre2", 1'b1, 32'h1000_0038, 32'hC3C3_C3C3, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rd_req  = (c < 9);
      rd_addr = (c < 3) ? 32'h1000_0030 : (c < 6) ? 32'h1000_0034 : 32'h1000_0038;
      #1;
      check1($sformatf("b2b_hold_c%0d", c), hold[3], (c < 9));
      if (c == 3) check("b2b_data0", rd_data[3], 32'hA1A1_A1A1);
      if (c == 6) check("b2b_data1", rd_data[3], 32'hB2B2_B2B2);
      if (c == 9) check("b2b_data2", rd_data[3], 32'hC3C3_C3C3);
    end
    clear_inputs();
    wait_idle("b2b_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
